// File: rtl/mux_nx1_pipe_pkg.sv
// Shared constants and helpers for the pipelined N:1 word multiplexer.
// Default geometry, miss counter width and a ceil-log2 helper for parameter defaults.
package mux_nx1_pipe_pkg;

    localparam int MUX_DEF_NUM_IN = 32;
    localparam int MUX_DEF_DATA_W = 32;
    localparam int MUX_MISS_CNT_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nx1_pipe_tree.sv
// Combinational NUM_IN:1 word selector, used twice by mux_nx1_pipe as the
// lower and upper half-trees of the first pipeline stage.
module mux_tree_nx1
    import mux_nx1_pipe_pkg::*;
#(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 32,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Two-stage pipelined N:1 word multiplexer with valid/ready handshake.
// Optional saturating miss counter enabled by defining MUX_NX1_MISS_CNT_EN.
module mux_nx1_pipe
    import mux_nx1_pipe_pkg::*;
#(
    parameter int NUM_IN = MUX_DEF_NUM_IN,
    parameter int DATA_W = MUX_DEF_DATA_W,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_vld,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      req_vld,
    output logic                      req_rdy,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_idx,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [MUX_MISS_CNT_W-1:0] miss_cnt
);

    localparam int HALF_N = NUM_IN / 2;
    localparam int HALF_W = HALF_N * DATA_W;

    if (SEL_W != clog2(NUM_IN) || NUM_IN < 4 || (1 << SEL_W) != NUM_IN) begin : g_bad_params
        $error("mux_nx1_pipe: NUM_IN must be a power of 2 >= 4 and SEL_W = log2(NUM_IN)");
    end

    logic              accept, hit, s2_adv;
    logic [DATA_W-1:0] lo_word, hi_word;

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_lo_q, s1_lo_d;
    logic [DATA_W-1:0] s1_hi_q, s1_hi_d;
    logic              s1_msb_q, s1_msb_d;
    logic [SEL_W-1:0]  s1_sel_q, s1_sel_d;

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_idx_q, out_idx_d;

    mux_tree_nx1 #(.NUM_IN(HALF_N), .DATA_W(DATA_W), .SEL_W(SEL_W-1)) u_tree_lo (
        .in_data  (in_data[HALF_W-1:0]),
        .sel      (sel[SEL_W-2:0]),
        .out_data (lo_word)
    );

    mux_tree_nx1 #(.NUM_IN(HALF_N), .DATA_W(DATA_W), .SEL_W(SEL_W-1)) u_tree_hi (
        .in_data  (in_data[NUM_IN*DATA_W-1:HALF_W]),
        .sel      (sel[SEL_W-2:0]),
        .out_data (hi_word)
    );

    // S1 may refill in the same cycle it hands its entry to S2.
    assign s2_adv  = !out_vld_q || out_rdy;
    assign req_rdy = !s1_vld_q || s2_adv;
    assign accept  = req_vld && req_rdy;
    assign hit     = accept && in_vld[sel];

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_lo_d  = s1_lo_q;
        s1_hi_d  = s1_hi_q;
        s1_msb_d = s1_msb_q;
        s1_sel_d = s1_sel_q;
        if (hit) begin
            s1_vld_d = 1'b1;
            s1_lo_d  = lo_word;
            s1_hi_d  = hi_word;
            s1_msb_d = sel[SEL_W-1];
            s1_sel_d = sel;
        end else if (s1_vld_q && s2_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        if (s2_adv) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_data_d = s1_msb_q ? s1_hi_q : s1_lo_q;
                out_idx_d  = s1_sel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_lo_q    <= '0;
            s1_hi_q    <= '0;
            s1_msb_q   <= 1'b0;
            s1_sel_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_lo_q    <= s1_lo_d;
            s1_hi_q    <= s1_hi_d;
            s1_msb_q   <= s1_msb_d;
            s1_sel_q   <= s1_sel_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_idx  = out_idx_q;

`ifdef MUX_NX1_MISS_CNT_EN
    logic                      miss;
    logic [MUX_MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    assign miss = accept && !in_vld[sel];

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss && (miss_cnt_q != {MUX_MISS_CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe (32 x 32-bit build), with a
// transaction-level scoreboard; honours MUX_NX1_MISS_CNT_EN for miss_cnt.
module tb_mux_nx1_pipe;

    localparam int NUM_IN = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  idx;
        int                ready;
    } item_t;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_vld;
    logic [SEL_W-1:0]         sel;
    logic                     req_vld;
    logic                     req_rdy;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_idx;
    logic                     out_vld;
    logic                     out_rdy;
    logic [7:0]               miss_cnt;

    logic [DATA_W-1:0] words [NUM_IN];
    item_t             exp_q [$];
    int                cyc;
    int                miss_exp;
    int                n_cmp;
    int                n_bad;
    int                n_out;

    mux_nx1_pipe #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .sel      (sel),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .miss_cnt (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic load_words();
        for (int k = 0; k < NUM_IN; k++) begin
            in_data[k*DATA_W +: DATA_W] = words[k];
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model, wait for the next falling edge.
    task automatic step(input logic r_vld, input int s, input logic o_rdy);
        logic    exp_rdy, exp_vld, acc;
        int      front_ready;
        item_t   it;
        req_vld = r_vld;
        sel     = SEL_W'(s);
        out_rdy = o_rdy;
        #1;
        exp_rdy = (exp_q.size() < 2) || o_rdy;
        exp_vld = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
        n_cmp++;
        if (req_rdy !== exp_rdy) begin
            n_bad++;
            $display("[TB] FAIL req_rdy cyc=%0d actual=%b required=%b", cyc, req_rdy, exp_rdy);
        end
        n_cmp++;
        if (out_vld !== exp_vld) begin
            n_bad++;
            $display("[TB] FAIL out_vld cyc=%0d actual=%b required=%b", cyc, out_vld, exp_vld);
        end
        if (exp_vld) begin
            n_cmp++;
            if (out_data !== exp_q[0].data || out_idx !== exp_q[0].idx) begin
                n_bad++;
                $display("[TB] FAIL out_word cyc=%0d actual=%h/%0d required=%h/%0d",
                         cyc, out_data, out_idx, exp_q[0].data, exp_q[0].idx);
            end
        end
        n_cmp++;
        if (miss_cnt !== 8'(miss_exp)) begin
            n_bad++;
            $display("[TB] FAIL miss_cnt cyc=%0d actual=%0d required=%0d", cyc, miss_cnt, miss_exp);
        end
        if (exp_vld && o_rdy) begin
            void'(exp_q.pop_front());
            n_out++;
            if (exp_q.size() > 0) begin
                front_ready = exp_q[0].ready;
                exp_q[0].ready = (front_ready > cyc + 1) ? front_ready : cyc + 1;
            end
        end
        acc = r_vld && exp_rdy;
        if (acc && in_vld[s]) begin
            it.data  = words[s];
            it.idx   = SEL_W'(s);
            it.ready = cyc + 2;
            exp_q.push_back(it);
        end else if (acc) begin
`ifdef MUX_NX1_MISS_CNT_EN
            if (miss_exp < 255) miss_exp++;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            step(1'b0, 0, 1'b1);
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req_vld = 1'b0;
        out_rdy = 1'b1;
        sel     = '0;
        in_vld  = '1;
        for (int k = 0; k < NUM_IN; k++) words[k] = 32'hA500_0000 + k;
        load_words();
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || out_data !== '0 || out_idx !== '0 || miss_cnt !== 8'h00 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_state actual=%b/%h/%0d/%0d/%b required=0/0/0/0/1",
                     out_vld, out_data, out_idx, miss_cnt, req_rdy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        miss_exp = 0;
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 4, 1'b0);
        step(1'b1, 20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || out_data !== '0 || out_idx !== '0 || miss_cnt !== 8'h00 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL midstream_reset actual=%b/%h/%0d/%0d/%b required=0/0/0/0/1",
                     out_vld, out_data, out_idx, miss_cnt, req_rdy);
        end
        req_vld = 1'b0;
        exp_q.delete();
        miss_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_streaming();
        int start_out;
        for (int k = 0; k < NUM_IN; k++) words[k] = 32'hA500_0000 + k;
        load_words();
        in_vld = '1;
        start_out = n_out;
        for (int k = 0; k < NUM_IN; k++) step(1'b1, k, 1'b1);
        drain();
        n_cmp++;
        if (n_out - start_out != NUM_IN) begin
            n_bad++;
            $display("[TB] FAIL stream_count actual=%0d required=%0d", n_out - start_out, NUM_IN);
        end
    endtask

    task automatic test_stall();
        in_vld = '1;
        step(1'b1, 3, 1'b0);
        step(1'b1, 17, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        drain();
    endtask

    task automatic test_miss();
        in_vld    = '1;
        in_vld[9] = 1'b0;
        step(1'b1, 9, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
        in_vld = '1;
    endtask

    task automatic test_saturation();
        in_vld    = '1;
        in_vld[9] = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1, 9, 1'b1);
        step(1'b0, 0, 1'b1);
        n_cmp++;
`ifdef MUX_NX1_MISS_CNT_EN
        if (miss_cnt !== 8'hFF) begin
            n_bad++;
            $display("[TB] FAIL saturation actual=%h required=ff", miss_cnt);
        end
`else
        if (miss_cnt !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL saturation actual=%h required=00", miss_cnt);
        end
`endif
        in_vld = '1;
    endtask

    task automatic test_boundary();
        for (int k = 0; k < NUM_IN; k++) words[k] = $urandom;
        load_words();
        in_vld = '1;
        step(1'b1, 15, 1'b1);
        step(1'b1, 16, 1'b1);
        step(1'b1, 0, 1'b1);
        step(1'b1, 31, 1'b1);
        step(1'b1, 16, 1'b0);
        step(1'b1, 15, 1'b0);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                for (int k = 0; k < NUM_IN; k++) words[k] = $urandom;
                load_words();
                in_vld = $urandom;
            end
            step(1'($urandom_range(0, 3) != 0), $urandom_range(0, NUM_IN - 1),
                 1'($urandom_range(0, 2) != 0));
        end
        in_vld = '1;
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_out = 0;
        cyc   = 0;
        test_reset();
        test_streaming();
        test_stall();
        test_miss();
        test_boundary();
        test_random();
        test_saturation();
        test_reset_midstream();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
